regfile_wb_sched: RTL

Write-back scheduler and scoreboard for the 32x32 integer register file, which has a single write port. It shares that port between three write-back sources (ALU, load/store unit, mul/div unit) using round-robin arbitration. It also tracks which destination registers have an issued but not yet written result, and it flags read-after-write and write-after-write hazards to the decode stage. It sits between the execute-stage units and the register file write port.

---
 rtl/regfile_wb_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and scoreboard for the 32x32 integer register file.
// Round-robin arbitration of ALU/LSU/MDU onto the single write port.
module regfile_wb_sched #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_rd,
    input  logic [ADDR_W-1:0]     rs1_addr,
    input  logic [ADDR_W-1:0]     rs2_addr,
    output logic                  haz_rs1,
    output logic                  haz_rs2,
    output logic                  haz_rd,
    input  logic [2:0]            src_valid,
    input  logic [3*ADDR_W-1:0]   src_addr,
    input  logic [3*DATA_W-1:0]   src_data,
    output logic [2:0]            src_ready,
    output logic                  wb_we,
    output logic [ADDR_W-1:0]     wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic [5:0]            pend_cnt
);

    localparam int NSRC = 3;

    logic [1:0]        ptr;
    logic [NSRC-1:0]   gnt;
    logic              gnt_any;
    logic [1:0]        gnt_idx;
    logic [1:0]        scan_idx;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic [NREG-1:0]   pending;
    logic              set_en;
    logic              clr_en;
    logic              inc;
    logic              dec;

    // Reduce a small sum modulo 3 (inputs never exceed 5).
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        logic [2:0] r;
        r = (v >= 3'd3) ? (v - 3'd3) : v;
        return r[1:0];
    endfunction

    // Round-robin scan starting at ptr; first valid source wins.
    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_idx  = 2'd0;
        scan_idx = 2'd0;
        for (int k = 0; k < NSRC; k++) begin
            scan_idx = wrap3({1'b0, ptr} + 3'(k));
            if (!gnt_any && src_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign src_ready = gnt;

    // Select the granted source's address and data.
    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        unique case (1'b1)
            gnt[0]: begin
                gnt_addr = src_addr[0*ADDR_W +: ADDR_W];
                gnt_data = src_data[0*DATA_W +: DATA_W];
            end
            gnt[1]: begin
                gnt_addr = src_addr[1*ADDR_W +: ADDR_W];
                gnt_data = src_data[1*DATA_W +: DATA_W];
            end
            gnt[2]: begin
                gnt_addr = src_addr[2*ADDR_W +: ADDR_W];
                gnt_data = src_data[2*DATA_W +: DATA_W];
            end
            default: begin
                gnt_addr = '0;
                gnt_data = '0;
            end
        endcase
    end

    // Pointer moves past the winner; holds when nobody is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (gnt_any) begin
            ptr <= wrap3({1'b0, gnt_idx} + 3'd1);
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (gnt_any) begin
            wb_we   <= (gnt_addr != '0);
            wb_addr <= gnt_addr;
            wb_data <= gnt_data;
        end else begin
            wb_we   <= 1'b0;
        end
    end

    assign set_en = iss_valid && (iss_rd != '0);
    assign clr_en = gnt_any && (gnt_addr != '0);

    // Count moves only when a bit actually changes state.
    assign inc = set_en && !pending[iss_rd];
    assign dec = clr_en && pending[gnt_addr]
               && !(set_en && (iss_rd == gnt_addr));

    // Set after clear so a newly issued owner keeps the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (clr_en) begin
                pending[gnt_addr] <= 1'b0;
            end
            if (set_en) begin
                pending[iss_rd] <= 1'b1;
            end
        end
    end

    // Incremental population count of the scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt <= '0;
        end else begin
            pend_cnt <= pend_cnt + 6'(inc) - 6'(dec);
        end
    end

    assign haz_rs1 = pending[rs1_addr];
    assign haz_rs2 = pending[rs2_addr];
    assign haz_rd  = pending[iss_rd];

endmodule
